fifo_w16_r1_serializer: RTL and testbench
=========================================

# fifo_w16_r1_serializer

- Single-clock FIFO that accepts 16-bit words and delivers them one bit at a time, MSB first.
- Mirror of the 1-bit-in / 16-bit-out capture FIFO on the acquisition side.
- Sits on the stimulation path: the host/USB side pushes pattern words, and the electrode driver pops one bit per `rd_en` strobe.
- Streams back-to-back words with no bubble.

## Interface
Parameters:
- `ADDR_WIDTH`, 6, log2 of word-memory depth (DEPTH = 64 words).

Ports:
- `clk` input 1: single system clock, rising-edge.
- `rst` input 1: asynchronous, active-high reset; clears all state.
- `din` input 16: word to enqueue.
- `wr_en` input 1: enqueue `din` on this edge if `full`=0.
- `rd_en` input 1: pop next bit on this edge if `empty`=0.
- `dout` output 1: registered serial bit.
- `full` output 1: word memory holds DEPTH words.
- `empty` output 1: no bit available to pop.
- `data_count` output ADDR_WIDTH+1: words in memory, excluding the word being shifted.

## Operation
- Storage:
  - DEPTH-word circular memory with write and read pointers of ADDR_WIDTH+1 bits; the MSB is the wrap bit.
  - One active-word register `act[15:0]`, a 4-bit `bit_idx`, and an `act_valid` flag.
  - Total capacity is DEPTH+1 words.
- Write:
  - When `wr_en` and `!full`: store `din` at wptr and increment wptr.
  - When `wr_en` and `full`: drop the write; no state changes.
- Load:
  - When `!act_valid` and memory is non-empty: move mem[rptr] into `act`, set `bit_idx`=0, set `act_valid`=1, increment rptr.
- Read:
  - When `rd_en` and `act_valid`: `dout` <= `act[15-bit_idx]`, then `bit_idx`++.
  - If `bit_idx`==15 and memory is non-empty: load the next word on the same edge (prefetch) and leave `act_valid` at 1.
  - If `bit_idx`==15 and memory is empty: `act_valid` <= 0.
- Empty read: `rd_en` while `empty`=1 is ignored; `dout` holds its last value.
- Flags:
  - `empty` = `!act_valid`.
  - `full` = (wptr − rptr == DEPTH).
  - `data_count` = wptr − rptr.
- Simultaneous write and read (including a load on the same edge): both take effect. `data_count` nets the write against the load.
- Write while full on the same edge as a load: the write is still dropped, because `full` is evaluated before the edge.
- Wrap-around: pointer arithmetic is modulo 2^(ADDR_WIDTH+1), and the memory index is ptr[ADDR_WIDTH-1:0].
- Reset mid-operation flushes everything: the partial word, memory contents, and pointers.

## Timing
- Reset values: `dout`=0, `full`=0, `empty`=1, `data_count`=0, `bit_idx`=0, `act_valid`=0, pointers=0.
- Write-to-empty latency:
  - Write at edge N into an empty FIFO: `data_count`=1 after N.
  - Load at N+1: `empty`=0 and `data_count`=0 after N+1.
  - First pop is possible at edge N+2.
- Read latency: 1 cycle. A `rd_en` sampled at edge k with `empty`=0 gives the new `dout` valid after edge k.
- `empty` rises after the edge that pops bit 15 of the last word.
- Streaming: with `rd_en` held and memory non-empty, 16·n consecutive bits come out with no gap.
- `full` deasserts after the edge on which a load occurs.

## Configuration
- `SER_LSB_FIRST_EN`:
  - Defined: each word is shifted LSB first, i.e. `dout` <= `act[bit_idx]`.
  - Undefined (default): MSB first, i.e. `act[15-bit_idx]`.
  - Flags, latency and capacity are identical in both builds.

## Test plan
1. Reset, then idle: `empty`=1, `full`=0, `dout`=0, `data_count`=0. Assert `rst` mid-stream after 5 bits of 16'hAAF0 have been popped: all flags return to their reset values immediately.
2. Write 16'hAAF0, wait 2 cycles, hold `rd_en` for 16 cycles:
   - `dout` = 1,0,1,0,1,0,1,0,1,1,1,1,0,0,0,0.
   - `empty`=1 after the 16th pop.
   - With `SER_LSB_FIRST_EN` defined: 0,0,0,0,1,1,1,1,0,1,0,1,0,1,0,1.
3. Write 16'hAAF0 and 16'h550F back-to-back, then read 32 bits continuously:
   - No bubble at bit 16.
   - Second word bits are 0,1,0,1,0,1,0,1,0,0,0,0,1,1,1,1.
4. Write 65 words with no reads:
   - `full`=1 once `data_count`=64 (the first word sits in `act`).
   - A 66th write is dropped.
   - Pop 16 bits: `full`=0 and `data_count`=63 after the load edge.
5. Pointer wrap: stream 200 words of an incrementing pattern while reading concurrently. Every word is reconstructed correctly, and `data_count` never exceeds 64.
6. Pop with `empty`=1 for 3 cycles: `dout` holds its value, `empty` stays 1, and pointers do not move.

Source files
------------

// File: rtl/fifo_w16_r1_serializer.sv
// 16-bit-in / 1-bit-out FIFO: word memory plus one active shift word, streamed MSB first.
// Define SER_LSB_FIRST_EN to shift each word out LSB first instead.
module fifo_w16_r1_serializer #(
    parameter int ADDR_WIDTH = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [15:0]           din,
    input  logic                  wr_en,
    input  logic                  rd_en,
    output logic                  dout,
    output logic                  full,
    output logic                  empty,
    output logic [ADDR_WIDTH:0]   data_count
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    logic [15:0]         mem_q [DEPTH];
    logic [ADDR_WIDTH:0] wptr_q, wptr_d;
    logic [ADDR_WIDTH:0] rptr_q, rptr_d;
    logic [15:0]         act_q, act_d;
    logic [3:0]          bit_idx_q, bit_idx_d;
    logic                act_valid_q, act_valid_d;
    logic                dout_q, dout_d;

    logic [ADDR_WIDTH:0] count;
    logic                mem_nonempty;
    logic                do_write;
    logic                do_pop;
    logic                last_bit;
    logic                do_load;
    logic                ser_bit;

    assign count        = wptr_q - rptr_q;
    assign mem_nonempty = (count != '0);
    assign full         = (count == (ADDR_WIDTH+1)'(DEPTH));
    assign empty        = !act_valid_q;
    assign data_count   = count;
    assign dout         = dout_q;

    assign do_write = wr_en && !full;
    assign do_pop   = rd_en && act_valid_q;
    assign last_bit = do_pop && (bit_idx_q == 4'd15);
    // A load refills an idle shifter, or prefetches on the final bit so streaming has no bubble.
    assign do_load  = mem_nonempty && (!act_valid_q || last_bit);

    always_comb begin
`ifdef SER_LSB_FIRST_EN
        ser_bit = act_q[bit_idx_q];
`else
        ser_bit = act_q[4'd15 - bit_idx_q];
`endif
    end

    always_comb begin
        wptr_d      = wptr_q;
        rptr_d      = rptr_q;
        act_d       = act_q;
        bit_idx_d   = bit_idx_q;
        act_valid_d = act_valid_q;
        dout_d      = dout_q;

        if (do_write) begin
            wptr_d = wptr_q + 1'b1;
        end
        if (do_pop) begin
            dout_d    = ser_bit;
            bit_idx_d = bit_idx_q + 4'd1;
            if (last_bit) begin
                act_valid_d = 1'b0;
            end
        end
        if (do_load) begin
            act_d       = mem_q[rptr_q[ADDR_WIDTH-1:0]];
            bit_idx_d   = 4'd0;
            act_valid_d = 1'b1;
            rptr_d      = rptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr_q      <= '0;
            rptr_q      <= '0;
            act_q       <= '0;
            bit_idx_q   <= '0;
            act_valid_q <= 1'b0;
            dout_q      <= 1'b0;
        end else begin
            wptr_q      <= wptr_d;
            rptr_q      <= rptr_d;
            act_q       <= act_d;
            bit_idx_q   <= bit_idx_d;
            act_valid_q <= act_valid_d;
            dout_q      <= dout_d;
        end
    end

    // Memory contents are cleared on reset so a flushed FIFO never replays stale words.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (do_write) begin
            mem_q[wptr_q[ADDR_WIDTH-1:0]] <= din;
        end
    end

endmodule

// File: tb/tb_fifo_w16_r1_serializer.sv
// Self-checking bench for fifo_w16_r1_serializer: a bit-level scoreboard is filled on each
// accepted write and drained on each pop, plus directed flag checks around reset and full.
module tb_fifo_w16_r1_serializer;

    logic        clk;
    logic        rst;
    logic [15:0] din;
    logic        wr_en;
    logic        rd_en;
    logic        dout;
    logic        full;
    logic        empty;
    logic [6:0]  data_count;

    int compared;
    int mismatched;
    bit expQ[$];
    bit expDout;

    fifo_w16_r1_serializer #(.ADDR_WIDTH(6)) dut (
        .clk        (clk),
        .rst        (rst),
        .din        (din),
        .wr_en      (wr_en),
        .rd_en      (rd_en),
        .dout       (dout),
        .full       (full),
        .empty      (empty),
        .data_count (data_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Expected serial order of a word, as the electrode driver should see it.
    task automatic pushWord(input logic [15:0] w);
        for (int b = 0; b < 16; b++) begin
`ifdef SER_LSB_FIRST_EN
            expQ.push_back(w[b]);
`else
            expQ.push_back(w[15-b]);
`endif
        end
    endtask

    task automatic test_reset;
        logic [15:0] w;
        rst = 1'b1; wr_en = 1'b0; rd_en = 1'b0; din = '0;
        tick; tick;
        rst = 1'b0;
        tick;
        compared++;
        if (empty !== 1'b1 || full !== 1'b0 || dout !== 1'b0 || data_count !== 7'd0) begin
            mismatched++;
            $display("[TB] FAIL reset_idle: empty=%b full=%b dout=%b count=%0d, need 1 0 0 0",
                     empty, full, dout, data_count);
        end
        // Build a partial stream with one extra word queued, then reset mid-word.
        w = 16'hAAF0;
        din = w; wr_en = 1'b1; tick; pushWord(w);
        din = 16'h1234; tick; pushWord(16'h1234);
        wr_en = 1'b0;
        rd_en = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick;
            expDout = expQ.pop_front();
            compared++;
            if (dout !== expDout) begin
                mismatched++;
                $display("[TB] FAIL reset_prebits[%0d]: dout=%b, need %b", i, dout, expDout);
            end
        end
        rd_en = 1'b0;
        compared++;
        if (data_count !== 7'd1 || empty !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL reset_prestate: count=%0d empty=%b, need 1 0", data_count, empty);
        end
        #2 rst = 1'b1;
        #1;
        compared++;
        if (empty !== 1'b1 || full !== 1'b0 || dout !== 1'b0 || data_count !== 7'd0) begin
            mismatched++;
            $display("[TB] FAIL reset_midstream: empty=%b full=%b dout=%b count=%0d, need 1 0 0 0",
                     empty, full, dout, data_count);
        end
        expQ.delete();
        expDout = 1'b0;
        tick;
        rst = 1'b0;
        tick;
    endtask

    task automatic test_single_word;
        din = 16'hAAF0; wr_en = 1'b1;
        tick; pushWord(16'hAAF0);
        wr_en = 1'b0;
        compared++;
        if (data_count !== 7'd1 || empty !== 1'b1) begin
            mismatched++;
            $display("[TB] FAIL single_write: count=%0d empty=%b, need 1 1", data_count, empty);
        end
        tick;
        compared++;
        if (data_count !== 7'd0 || empty !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL single_load: count=%0d empty=%b, need 0 0", data_count, empty);
        end
        rd_en = 1'b1;
        for (int i = 0; i < 16; i++) begin
            tick;
            expDout = expQ.pop_front();
            compared++;
            if (dout !== expDout || empty !== (i == 15)) begin
                mismatched++;
                $display("[TB] FAIL single_bit[%0d]: dout=%b empty=%b, need %b %b",
                         i, dout, empty, expDout, (i == 15));
            end
        end
        rd_en = 1'b0;
    endtask

    task automatic test_back_to_back;
        wr_en = 1'b1;
        din = 16'hAAF0; tick; pushWord(16'hAAF0);
        din = 16'h550F; tick; pushWord(16'h550F);
        wr_en = 1'b0;
        rd_en = 1'b1;
        for (int i = 0; i < 32; i++) begin
            tick;
            expDout = expQ.pop_front();
            compared++;
            if (dout !== expDout || empty !== (i == 31)) begin
                mismatched++;
                $display("[TB] FAIL b2b_bit[%0d]: dout=%b empty=%b, need %b %b",
                         i, dout, empty, expDout, (i == 31));
            end
        end
        rd_en = 1'b0;
    endtask

    task automatic test_full;
        int guard;
        wr_en = 1'b1;
        for (int i = 0; i < 65; i++) begin
            din = 16'h1000 + 16'(i);
            tick;
            pushWord(din);
        end
        compared++;
        if (full !== 1'b1 || data_count !== 7'd64) begin
            mismatched++;
            $display("[TB] FAIL full_reach: full=%b count=%0d, need 1 64", full, data_count);
        end
        din = 16'hFFFF;
        tick;
        wr_en = 1'b0;
        compared++;
        if (full !== 1'b1 || data_count !== 7'd64) begin
            mismatched++;
            $display("[TB] FAIL full_drop: full=%b count=%0d, need 1 64", full, data_count);
        end
        rd_en = 1'b1;
        for (int i = 0; i < 16; i++) begin
            tick;
            expDout = expQ.pop_front();
            compared++;
            if (dout !== expDout) begin
                mismatched++;
                $display("[TB] FAIL full_bit[%0d]: dout=%b, need %b", i, dout, expDout);
            end
        end
        compared++;
        if (full !== 1'b0 || data_count !== 7'd63) begin
            mismatched++;
            $display("[TB] FAIL full_release: full=%b count=%0d, need 0 63", full, data_count);
        end
        guard = 0;
        while (expQ.size() > 0 && guard < 2000) begin
            if (empty) begin
                compared++; mismatched++;
                $display("[TB] FAIL full_drain_early: empty=1 with %0d bits pending, need 0",
                         expQ.size());
                expQ.delete();
                break;
            end
            tick;
            guard++;
            expDout = expQ.pop_front();
            compared++;
            if (dout !== expDout) begin
                mismatched++;
                $display("[TB] FAIL full_drain_bit[%0d]: dout=%b, need %b", guard, dout, expDout);
            end
        end
        rd_en = 1'b0;
        compared++;
        if (empty !== 1'b1 || data_count !== 7'd0) begin
            mismatched++;
            $display("[TB] FAIL full_drained: empty=%b count=%0d, need 1 0", empty, data_count);
        end
    endtask

    task automatic test_wrap;
        int sent;
        int cycles;
        logic wr;
        logic rd;
        logic preEmpty;
        logic preFull;
        sent = 0;
        cycles = 0;
        while ((sent < 200 || expQ.size() > 0) && cycles < 20000) begin
            wr = (sent < 200) && ($urandom_range(7) == 0);
            rd = ($urandom_range(7) != 0);
            preEmpty = empty;
            preFull = full;
            din = 16'hC000 + 16'(sent);
            wr_en = wr;
            rd_en = rd;
            tick;
            cycles++;
            if (wr && !preFull) begin
                pushWord(din);
                sent++;
            end
            if (rd && !preEmpty) begin
                compared++;
                if (expQ.size() == 0) begin
                    mismatched++;
                    $display("[TB] FAIL wrap_extra_bit: dout=%b popped, need no data", dout);
                end else begin
                    expDout = expQ.pop_front();
                    if (dout !== expDout) begin
                        mismatched++;
                        $display("[TB] FAIL wrap_bit word=%0d: dout=%b, need %b",
                                 sent, dout, expDout);
                    end
                end
            end
            compared++;
            if (data_count > 7'd64) begin
                mismatched++;
                $display("[TB] FAIL wrap_count: count=%0d, need <=64", data_count);
            end
        end
        wr_en = 1'b0;
        rd_en = 1'b0;
        compared++;
        if (expQ.size() != 0 || sent != 200 || empty !== 1'b1) begin
            mismatched++;
            $display("[TB] FAIL wrap_done: pending=%0d sent=%0d empty=%b, need 0 200 1",
                     expQ.size(), sent, empty);
            expQ.delete();
        end
    endtask

    task automatic test_empty_read;
        rd_en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick;
            compared++;
            if (dout !== expDout || empty !== 1'b1 || data_count !== 7'd0) begin
                mismatched++;
                $display("[TB] FAIL empty_read[%0d]: dout=%b empty=%b count=%0d, need %b 1 0",
                         i, dout, empty, data_count, expDout);
            end
        end
        rd_en = 1'b0;
        din = 16'h0F3C; wr_en = 1'b1;
        tick; pushWord(16'h0F3C);
        wr_en = 1'b0;
        tick;
        compared++;
        if (empty !== 1'b0 || data_count !== 7'd0) begin
            mismatched++;
            $display("[TB] FAIL empty_reload: empty=%b count=%0d, need 0 0", empty, data_count);
        end
        rd_en = 1'b1;
        for (int i = 0; i < 16; i++) begin
            tick;
            expDout = expQ.pop_front();
            compared++;
            if (dout !== expDout) begin
                mismatched++;
                $display("[TB] FAIL empty_after_bit[%0d]: dout=%b, need %b", i, dout, expDout);
            end
        end
        rd_en = 1'b0;
    endtask

    initial begin
        compared = 0;
        mismatched = 0;
        expDout = 1'b0;
        rst = 1'b1; wr_en = 1'b0; rd_en = 1'b0; din = '0;
        test_reset;
        test_single_word;
        test_back_to_back;
        test_full;
        test_wrap;
        test_empty_read;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
